// File: rtl/team2_button_conditioner.sv
// Synchronises, debounces and arbitrates the active-low up/down buttons into clean levels and step pulses.
// Optional auto-repeat of step pulses while a single button is held: define BTN_REPEAT_EN.
module team2_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_PERIOD   = 100000,
  parameter int unsigned CNT_W           = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vu_raw,
  input  logic vd_raw,
  output logic vu_clean,
  output logic vd_clean,
  output logic up_step,
  output logic down_step,
  output logic conflict
);

  if (DEBOUNCE_CYCLES == 0 || REPEAT_PERIOD == 0 ||
      DEBOUNCE_CYCLES > (1 << CNT_W) || REPEAT_PERIOD > (1 << CNT_W)) begin : g_bad_cfg
    $error("team2_button_conditioner: CNT_W too small or zero period");
  end

  typedef enum logic [1:0] {IDLE, UP_HELD, DOWN_HELD, CONFLICT} state_t;

  // Bit 0 = up button, bit 1 = down button.
  logic [1:0]       sync_a;
  logic [1:0]       sync_b;
  logic [1:0]       clean;
  logic [CNT_W-1:0] db_cnt [2];

  state_t state;
  state_t nxt;
  logic   rpt_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '1;
      sync_b <= '1;
      clean  <= '1;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_a <= {vd_raw, vu_raw};
      sync_b <= sync_a;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync_b[i] == clean[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          clean[i]  <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    nxt = IDLE;
    case (clean)
      2'b00:   nxt = CONFLICT;
      2'b10:   nxt = UP_HELD;
      2'b01:   nxt = DOWN_HELD;
      default: nxt = IDLE;
    endcase
  end

`ifdef BTN_REPEAT_EN
  logic [CNT_W-1:0] rpt_cnt;

  assign rpt_fire = (nxt == state) && (state == UP_HELD || state == DOWN_HELD) &&
                    (rpt_cnt == CNT_W'(REPEAT_PERIOD - 1));

  // Cleared on entry and on every repeat pulse, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt <= '0;
    end else if ((nxt == UP_HELD || nxt == DOWN_HELD) && nxt == state && !rpt_fire) begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end else begin
      rpt_cnt <= '0;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // A step is issued on the edge that enters a held state (including re-entry from CONFLICT).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      up_step   <= 1'b0;
      down_step <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      state     <= nxt;
      conflict  <= (clean == 2'b00);
      up_step   <= (nxt == UP_HELD)   && ((nxt != state) || rpt_fire);
      down_step <= (nxt == DOWN_HELD) && ((nxt != state) || rpt_fire);
    end
  end

  assign vu_clean = clean[0];
  assign vd_clean = clean[1];

endmodule

// File: tb/tb_team2_button_conditioner.sv
// Directed bench for team2_button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_PERIOD=8.
// Cycle k of a phase means the value seen 1 time unit after the k-th rising edge following the input change.
module tb_team2_button_conditioner;

`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic vu_raw;
  logic vd_raw;
  logic vu_clean;
  logic vd_clean;
  logic up_step;
  logic down_step;
  logic conflict;

  int unsigned total = 0;
  int unsigned bad   = 0;

  team2_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_PERIOD  (8),
    .CNT_W          (17)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vu_raw   (vu_raw),
    .vd_raw   (vd_raw),
    .vu_clean (vu_clean),
    .vd_clean (vd_clean),
    .up_step  (up_step),
    .down_step(down_step),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit eu, input bit ed,
                           input bit evu, input bit evd, input bit ec);
    check({tag, " up_step"},   32'(up_step),   32'(eu));
    check({tag, " down_step"}, 32'(down_step), 32'(ed));
    check({tag, " vu_clean"},  32'(vu_clean),  32'(evu));
    check({tag, " vd_clean"},  32'(vd_clean),  32'(evd));
    check({tag, " conflict"},  32'(conflict),  32'(ec));
  endtask

  task automatic tick(input string tag, input int k, input bit eu, input bit ed,
                      input bit evu, input bit evd, input bit ec);
    @(posedge clk);
    #1;
    check_all($sformatf("%s k=%0d", tag, k), eu, ed, evu, evd, ec);
  endtask

  initial begin
    rst_n  = 1'b0;
    vu_raw = 1'b1;
    vd_raw = 1'b1;
    #12;
    check_all("reset", 0, 0, 1, 1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset release
    for (int k = 1; k <= 20; k++) tick("idle", k, 0, 0, 1, 1, 0);

    // Single press and release of up
    vu_raw = 1'b0;
    for (int k = 1; k <= 8; k++) tick("up_press", k, k == 7, 0, k < 6, 1, 0);
    vu_raw = 1'b1;
    for (int k = 9; k <= 24; k++) tick("up_release", k, 0, 0, k >= 14, 1, 0);

    // 3-cycle glitch is rejected
    vu_raw = 1'b0;
    for (int k = 1; k <= 3; k++) tick("glitch", k, 0, 0, 1, 1, 0);
    vu_raw = 1'b1;
    for (int k = 4; k <= 15; k++) tick("glitch", k, 0, 0, 1, 1, 0);

    // Long down hold: repeat pulses only when enabled
    vd_raw = 1'b0;
    for (int k = 1; k <= 40; k++)
      tick("down_hold", k, 0, (k == 7) || (REP && k > 7 && ((k - 7) % 8) == 0), 1, k < 6, 0);
    vd_raw = 1'b1;
    for (int k = 41; k <= 52; k++) tick("down_release", k, 0, 0, 1, k >= 46, 0);

    // Up held, then down pressed -> conflict; release down -> new up press
    vu_raw = 1'b0;
    for (int k = 1; k <= 7; k++) tick("cf_up", k, k == 7, 0, k < 6, 1, 0);
    vd_raw = 1'b0;
    for (int k = 8; k <= 25; k++) tick("cf_both", k, 0, 0, 0, k < 13, k >= 14);
    vd_raw = 1'b1;
    for (int k = 26; k <= 36; k++) tick("cf_vd_rel", k, k == 32, 0, 0, k >= 31, k < 32);
    vu_raw = 1'b1;
    for (int k = 37; k <= 48; k++) tick("cf_vu_rel", k, REP && k == 40, 0, k >= 42, 1, 0);

    // Simultaneous press: conflict with no steps
    vu_raw = 1'b0;
    vd_raw = 1'b0;
    for (int k = 1; k <= 12; k++) tick("simul", k, 0, 0, k < 6, k < 6, k >= 7);
    vu_raw = 1'b1;
    vd_raw = 1'b1;
    for (int k = 13; k <= 24; k++) tick("simul_rel", k, 0, 0, k >= 18, k >= 18, k < 19);

    // Reset mid-hold at repeat count 5
    vu_raw = 1'b0;
    for (int k = 1; k <= 12; k++) tick("rst_hold", k, k == 7, 0, k < 6, 1, 0);
    rst_n = 1'b0;
    #1;
    check_all("rst_async", 0, 0, 1, 1, 0);
    for (int k = 13; k <= 16; k++) tick("rst_in", k, 0, 0, 1, 1, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) tick("rst_after", k, k == 7, 0, k < 6, 1, 0);
    vu_raw = 1'b1;
    for (int k = 11; k <= 20; k++) tick("rst_rel", k, REP && k == 15, 0, k >= 16, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
